// File: rtl/serial_adder_acc_if.sv
// Handshake and operand bundle for serial_adder_acc.
// The master side drives the request; the slave side is the adder itself.
interface serial_adder_acc_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             acc_mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, a, b, sub, acc_mode,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, a, b, sub, acc_mode,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_adder_acc.sv
// Digit-serial adder/subtractor with accumulate mode: DIGIT bits per clock, LSB first,
// start/busy/done handshake, result and flags published only when the operation completes.
module serial_adder_acc #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic              clk,
  input logic              reset,
  serial_adder_acc_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int STEPW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [WIDTH-1:0]   r_opA;
  logic [WIDTH-1:0]   r_opB;
  logic [WIDTH-1:0]   r_shadow;
  logic [WIDTH-1:0]   r_sum;
  logic [STEPW-1:0]   r_step;
  logic               r_aMsb;
  logic               r_bMsb;
  logic               r_carry;
  logic               r_carryOut;
  logic               r_overflow;

  logic               w_accept;
  logic               w_lastStep;
  logic [WIDTH-1:0]   w_opA;
  logic [WIDTH-1:0]   w_opB;
  logic [DIGIT:0]     w_digitSum;
  logic [WIDTH-1:0]   w_shadowNext;

  assign w_accept   = bus.start && (r_state != RUN);
  assign w_lastStep = (r_step == STEPW'(STEPS - 1));
  assign w_opA      = bus.acc_mode ? r_sum : bus.a;
  assign w_opB      = bus.sub ? ~bus.b : bus.b;

  // Operands shift right each step, so the active digit is always the low DIGIT bits.
  assign w_digitSum   = {1'b0, r_opA[DIGIT-1:0]} + {1'b0, r_opB[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, r_carry};
  assign w_shadowNext = WIDTH'({w_digitSum[DIGIT-1:0], r_shadow} >> DIGIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_stateNext = RUN;
      RUN:     if (w_lastStep) w_stateNext = DONE;
      DONE:    w_stateNext = bus.start ? RUN : IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Result and flags are loaded on the edge that enters DONE, so they are valid with done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_opA      <= '0;
      r_opB      <= '0;
      r_shadow   <= '0;
      r_sum      <= '0;
      r_step     <= '0;
      r_aMsb     <= 1'b0;
      r_bMsb     <= 1'b0;
      r_carry    <= 1'b0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_opA   <= w_opA;
      r_opB   <= w_opB;
      r_aMsb  <= w_opA[WIDTH-1];
      r_bMsb  <= w_opB[WIDTH-1];
      r_carry <= bus.sub;
      r_step  <= '0;
    end else if (r_state == RUN) begin
      r_opA    <= r_opA >> DIGIT;
      r_opB    <= r_opB >> DIGIT;
      r_carry  <= w_digitSum[DIGIT];
      r_shadow <= w_shadowNext;
      r_step   <= r_step + STEPW'(1);
      if (w_lastStep) begin
        r_sum      <= w_shadowNext;
        r_carryOut <= w_digitSum[DIGIT];
        r_overflow <= (r_aMsb == r_bMsb) && (w_shadowNext[WIDTH-1] != r_aMsb);
      end
    end
  end

  assign bus.busy      = (r_state == RUN);
  assign bus.done      = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_carryOut;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_serial_adder_acc.sv
// Bench for serial_adder_acc: an 8-bit/1-digit and a 16-bit/4-digit instance checked
// every cycle against an arithmetic reference model, plus directed literal scenarios.
module tb_serial_adder_acc;
  logic clk;
  logic reset;

  serial_adder_acc_if #(.WIDTH(8))  bus8();
  serial_adder_acc_if #(.WIDTH(16)) bus16();

  serial_adder_acc #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  serial_adder_acc #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  int total = 0;
  int bad   = 0;

  int     stepsOf[2] = '{8, 4};
  int     widthOf[2] = '{8, 16};
  int     left[2]    = '{0, 0};
  bit     eBusy[2]   = '{0, 0};
  bit     eDone[2]   = '{0, 0};
  bit     eCarry[2]  = '{0, 0};
  bit     eOvf[2]    = '{0, 0};
  longint eSum[2]    = '{0, 0};
  longint pSum[2]    = '{0, 0};
  bit     pCarry[2]  = '{0, 0};
  bit     pOvf[2]    = '{0, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain modular / signed arithmetic: what a WIDTH-bit add or subtract must produce.
  function automatic void calc(input int w, input longint opA, input longint b, input bit isSub,
                               output longint res, output bit cOut, output bit ovf);
    longint modv;
    longint half;
    longint sa;
    longint sb;
    longint sr;
    modv = longint'(1) << w;
    half = modv / 2;
    if (isSub) begin
      res  = (opA - b + modv) % modv;
      cOut = (opA >= b);
    end else begin
      res  = (opA + b) % modv;
      cOut = ((opA + b) >= modv);
    end
    sa  = (opA >= half) ? opA - modv : opA;
    sb  = (b >= half) ? b - modv : b;
    sr  = isSub ? sa - sb : sa + sb;
    ovf = (sr >= half) || (sr < -half);
  endfunction

  task automatic stepModel(input int d, input bit st, input longint a, input longint b,
                           input bit isSub, input bit acc);
    longint r;
    bit     c;
    bit     v;
    eDone[d] = 1'b0;
    if (left[d] > 0) begin
      left[d]--;
      if (left[d] == 0) begin
        eSum[d]   = pSum[d];
        eCarry[d] = pCarry[d];
        eOvf[d]   = pOvf[d];
        eDone[d]  = 1'b1;
      end
    end else if (st) begin
      calc(widthOf[d], acc ? eSum[d] : a, b, isSub, r, c, v);
      pSum[d]   = r;
      pCarry[d] = c;
      pOvf[d]   = v;
      left[d]   = stepsOf[d];
    end
    eBusy[d] = (left[d] > 0);
  endtask

  // Reference model: a countdown of remaining digit steps per instance.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        left[d] = 0; eBusy[d] = 0; eDone[d] = 0;
        eSum[d] = 0; eCarry[d] = 0; eOvf[d] = 0;
      end
    end else begin
      stepModel(0, bus8.start, bus8.a, bus8.b, bus8.sub, bus8.acc_mode);
      stepModel(1, bus16.start, bus16.a, bus16.b, bus16.sub, bus16.acc_mode);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("busy8", bus8.busy, eBusy[0]);
      checkOutput("done8", bus8.done, eDone[0]);
      checkOutput("sum8", bus8.sum, eSum[0]);
      checkOutput("carry8", bus8.carry_out, eCarry[0]);
      checkOutput("ovf8", bus8.overflow, eOvf[0]);
      checkOutput("busy16", bus16.busy, eBusy[1]);
      checkOutput("done16", bus16.done, eDone[1]);
      checkOutput("sum16", bus16.sum, eSum[1]);
      checkOutput("carry16", bus16.carry_out, eCarry[1]);
      checkOutput("ovf16", bus16.overflow, eOvf[1]);
    end
  end

  task automatic applyStimulus(input int d, input bit st, input longint a, input longint b,
                               input bit isSub, input bit acc);
    if (d == 0) begin
      bus8.start = st; bus8.a = 8'(a); bus8.b = 8'(b);
      bus8.sub = isSub; bus8.acc_mode = acc;
    end else begin
      bus16.start = st; bus16.a = 16'(a); bus16.b = 16'(b);
      bus16.sub = isSub; bus16.acc_mode = acc;
    end
  endtask

  // One 8-bit operation; n counts cycles with the cycle after the accept edge as 1.
  task automatic runOp8(input string name, input longint a, input longint b, input bit isSub,
                        input longint expSum, input bit expC, input bit expV);
    int n;
    @(negedge clk);
    applyStimulus(0, 1, a, b, isSub, 0);
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    n = 1;
    while (!bus8.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_latency"}, n, 9);
    checkOutput({name, "_sum"}, bus8.sum, expSum);
    checkOutput({name, "_carry"}, bus8.carry_out, expC);
    checkOutput({name, "_ovf"}, bus8.overflow, expV);
  endtask

  initial begin
    int     n;
    int     cnt;
    int     firstN;
    int     doneN[4];
    longint sums[4];
    bit     carries[4];
    longint got16;
    bit     gotC16;
    bit     gotV16;

    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy8", bus8.busy, 0);
    checkOutput("rst_done8", bus8.done, 0);
    checkOutput("rst_sum16", bus16.sum, 0);
    reset = 1'b0;

    runOp8("add", 8'h5A, 8'h33, 0, 8'h8D, 0, 1);

    @(negedge clk);
    applyStimulus(0, 1, 8'h10, 8'h20, 1, 0);
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    checkOutput("midrun_busy", bus8.busy, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_busy", bus8.busy, 0);
    checkOutput("midrst_done", bus8.done, 0);
    checkOutput("midrst_sum", bus8.sum, 0);
    checkOutput("midrst_ovf", bus8.overflow, 0);
    @(negedge clk);
    reset = 1'b0;

    runOp8("sub_borrow", 8'h10, 8'h20, 1, 8'hF0, 0, 0);
    runOp8("sub_noborrow", 8'h20, 8'h10, 1, 8'h10, 1, 0);

    @(negedge clk);
    applyStimulus(0, 1, 8'h01, 8'hFF, 0, 0);
    @(posedge clk);
    @(negedge clk);
    bus8.acc_mode = 1'b1;
    bus8.b = 8'h01;
    n = 1;
    cnt = 0;
    while (cnt < 4 && n < 60) begin
      if (bus8.done) begin
        doneN[cnt] = n; sums[cnt] = bus8.sum; carries[cnt] = bus8.carry_out;
        cnt++;
      end else if (cnt == 3 && bus8.start) begin
        bus8.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus8.start = 1'b0;
    checkOutput("chain_count", cnt, 4);
    if (cnt == 4) begin
      checkOutput("chain_first_latency", doneN[0], 9);
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("chain_sum%0d", k), sums[k], k);
        if (k > 0) checkOutput($sformatf("chain_gap%0d", k), doneN[k] - doneN[k-1], 9);
      end
      checkOutput("chain_carry0", carries[0], 1);
      checkOutput("chain_carry1", carries[1], 0);
    end

    @(negedge clk);
    applyStimulus(1, 1, 16'h7FFF, 16'h0001, 0, 0);
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    n = 1; cnt = 0; firstN = 0; got16 = 0; gotC16 = 0; gotV16 = 0;
    while (n <= 16) begin
      if (n == 2) bus16.start = 1'b1;
      if (n == 3) bus16.start = 1'b0;
      if (bus16.done) begin
        cnt++;
        if (cnt == 1) begin
          firstN = n; got16 = bus16.sum; gotC16 = bus16.carry_out; gotV16 = bus16.overflow;
        end
      end
      @(negedge clk);
      n++;
    end
    checkOutput("ign_done_count", cnt, 1);
    checkOutput("ign_latency", firstN, 5);
    checkOutput("ign_sum", got16, 16'h8000);
    checkOutput("ign_ovf", gotV16, 1);
    checkOutput("ign_carry", gotC16, 0);
    checkOutput("ign_idle", bus16.busy, 0);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      applyStimulus(0, $urandom_range(0, 2) == 0, $urandom_range(0, 255), $urandom_range(0, 255),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      applyStimulus(1, $urandom_range(0, 2) == 0, $urandom_range(0, 65535),
                    $urandom_range(0, 65535), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_adder_acc.md
# serial_adder_acc

Parametrised multi-cycle adder/subtractor with an accumulate mode. It processes DIGIT bits per clock, LSB digit first, and reports completion with a start/busy/done handshake. It generalises the team's single-cycle combinational adder core to arbitrary width, selectable add/subtract and a running accumulator. It sits behind the top-level pin wrapper, with operands and controls driven from the dedicated input pins.

## Interface
- WIDTH, 8: operand/result width in bits; must be ≥ 2.
- DIGIT, 1: bits processed per cycle; must divide WIDTH exactly. STEPS = WIDTH/DIGIT.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only when not busy.
- a  in  WIDTH  operand A, captured on accepted start.
- b  in  WIDTH  operand B, captured on accepted start.
- sub  in  1  0 = A+B, 1 = A−B; captured on accepted start.
- acc_mode  in  1  1 = use the current `sum` register in place of `a`; captured on accepted start.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse when `sum`/flags become valid.
- sum  out  WIDTH  result register; holds its value until the next completion.
- carry_out  out  1  unsigned carry out of the MSB; for subtract, 1 = no borrow.
- overflow  out  1  two's-complement signed overflow of the completed operation.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE. In reset, busy = done = carry_out = overflow = 0 and sum = 0.
- IDLE, start = 1: latch the operands and go to RUN.
  - opA = acc_mode ? sum : a.
  - opB = sub ? ~b : b.
  - carry register = sub.
  - step counter = 0.
- RUN, each cycle:
  - Add digit `step` of opA, opB and the carry register (DIGIT-bit slice, bits [step*DIGIT +: DIGIT]).
  - Write the DIGIT-bit result into the internal shadow result; update the carry register.
  - Increment the counter.
  - After step STEPS−1, go to DONE.
- DONE, one cycle:
  - Copy the shadow result to `sum`; set carry_out to the final carry.
  - Set overflow = (opA[MSB] == opB[MSB]) && (result[MSB] != opA[MSB]).
  - done = 1. Next state is IDLE, or RUN if start = 1 in this cycle (back-to-back accept).
- start while in RUN is ignored and is not queued.
- `sum` and the flags change only in the DONE cycle. Intermediate digits are never visible on `sum`.
- acc_mode reads `sum` as it stands at the accept edge. In a back-to-back accept from DONE, that is the newly completed result.
- All arithmetic is modulo 2^WIDTH. No saturation.
- Reset asserted mid-RUN: the operation is abandoned, `sum` clears to 0 and no done pulse is produced.

## Timing
- start is sampled high at rising edge T0 (IDLE or DONE).
  - busy is high for cycles T0+1 … T0+STEPS.
  - done is high and `sum` is valid in cycle T0+STEPS+1.
- Latency from accept to done is STEPS+1 cycles.
  - WIDTH = 8, DIGIT = 1: 9 cycles.
  - WIDTH = 8, DIGIT = 8: 2 cycles.
- Throughput with start held high: one result every STEPS+1 cycles.
- busy and done are never high together.
- Outputs are registered, with no combinational path from inputs to outputs.
- Reset is asynchronous: outputs take their reset values immediately, independent of clk. Release is synchronised externally.

## Test plan
- Reset check: assert reset mid-RUN (WIDTH = 8, DIGIT = 1, 3 cycles after start).
  - Required: busy = done = 0 and sum = 0 immediately.
  - A subsequent start completes normally.
- Basic add (WIDTH = 8, DIGIT = 1): a = 0x5A, b = 0x33, sub = 0.
  - Required: done 9 cycles after accept, sum = 0x8D, carry_out = 0, overflow = 1.
- Subtract with borrow: a = 0x10, b = 0x20, sub = 1.
  - Required: sum = 0xF0, carry_out = 0, overflow = 0.
  - Then a = 0x20, b = 0x10: sum = 0x10, carry_out = 1.
- Accumulate chain with start held high (back-to-back): first a = 0x01, b = 0xFF, acc_mode = 0; then three ops with acc_mode = 1, b = 0x01.
  - Required: sums 0x00 (carry_out = 1), 0x01, 0x02, 0x03, each done exactly 9 cycles apart.
- Busy-ignore and digit width (WIDTH = 16, DIGIT = 4): a = 0x7FFF, b = 0x0001; pulse start again during RUN.
  - Required: single done 5 cycles after the first accept.
  - sum = 0x8000, overflow = 1, carry_out = 0.
  - No second operation runs.
